// File: rtl/triangle_scan_ctrl_pkg.sv
// Shared types and widths for the triangle scan controller.
// Edge products are sized so that no difference or cross product can overflow.
package triangle_scan_ctrl_pkg;

   localparam int COORD_W_DEF = 11;
   localparam int DIFF_W_DEF  = COORD_W_DEF + 1;
   localparam int PROD_W_DEF  = 2 * COORD_W_DEF + 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BBOX  = 2'd1,
      SCAN  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   function automatic int diff_w(input int coord_w);
      return coord_w + 1;
   endfunction

   function automatic int prod_w(input int coord_w);
      return 2 * coord_w + 3;
   endfunction

endpackage

// File: rtl/triangle_scan_ctrl_if.sv
// Triangle-in / pixel-out handshake bundle for the scan controller.
// The slave modport is the controller side; the master side feeds triangles and drains pixels.
interface triangle_scan_ctrl_if
   import triangle_scan_ctrl_pkg::*;
   #(parameter int COORD_W = COORD_W_DEF);

   logic               tri_valid;
   logic               tri_ready;
   logic [COORD_W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
   logic               pix_valid;
   logic               pix_ready;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic               pix_inside;

   modport slave (
      input  tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y, pix_inside
   );

   modport master (
      output tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y, pix_inside
   );

endinterface

// File: rtl/triangle_scan_ctrl_tri_edge_sign.sv
// Signed cross product of one triangle edge against a point.
// Reports strict negative and strict positive so the caller can treat d=0 as on-edge.
module tri_edge_sign
   import triangle_scan_ctrl_pkg::*;
   #(parameter int COORD_W = COORD_W_DEF)
   (
      input  logic [COORD_W-1:0] i_ax,
      input  logic [COORD_W-1:0] i_ay,
      input  logic [COORD_W-1:0] i_bx,
      input  logic [COORD_W-1:0] i_by,
      input  logic [COORD_W-1:0] i_px,
      input  logic [COORD_W-1:0] i_py,
      output logic               o_neg,
      output logic               o_pos
   );

   localparam int DIFF_W = diff_w(COORD_W);
   localparam int PROD_W = prod_w(COORD_W);

   logic signed [DIFF_W-1:0] w_dpx, w_day, w_dax, w_dpy;
   logic signed [PROD_W-1:0] w_m0, w_m1, w_d;

   assign w_dpx = $signed({1'b0, i_px}) - $signed({1'b0, i_bx});
   assign w_day = $signed({1'b0, i_ay}) - $signed({1'b0, i_by});
   assign w_dax = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
   assign w_dpy = $signed({1'b0, i_py}) - $signed({1'b0, i_by});

   assign w_m0  = PROD_W'(w_dpx) * PROD_W'(w_day);
   assign w_m1  = PROD_W'(w_dax) * PROD_W'(w_dpy);
   assign w_d   = w_m0 - w_m1;

   assign o_neg = w_d[PROD_W-1];
   assign o_pos = !w_d[PROD_W-1] && (w_d != '0);

endmodule

// File: rtl/triangle_scan_ctrl.sv
// Bounding-box rasteriser: accepts a triangle, walks its box row-major, streams covered pixels.
// Build option EMIT_ALL_EN: emit every box pixel with pix_inside carrying the coverage result.
//
// state | meaning
// IDLE  | tri_ready high, waiting for a triangle
// BBOX  | compute bounding box, seed scan position
// SCAN  | test (cx,cy), push to output stage, step
// DRAIN | wait for the last pixel to be taken, then pulse done
module triangle_scan_ctrl
   import triangle_scan_ctrl_pkg::*;
   #(parameter int COORD_W = COORD_W_DEF)
   (
      input  logic                 clk,
      input  logic                 rst,
      triangle_scan_ctrl_if.slave  bus,
      output logic                 o_busy,
      output logic                 o_done
   );

   state_e             r_state;
   logic               r_tri_ready;
   logic               r_busy;
   logic               r_done;
   logic [COORD_W-1:0] r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
   logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
   logic [COORD_W-1:0] r_cx, r_cy;
   logic               r_pix_valid;
   logic [COORD_W-1:0] r_pix_x, r_pix_y;
   logic               r_pix_inside;

   logic w_neg12, w_pos12, w_neg23, w_pos23, w_neg31, w_pos31;
   logic w_inside, w_emit, w_flag, w_adv, w_last_col, w_last_row;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   tri_edge_sign #(.COORD_W(COORD_W)) u_e12 (
      .i_ax(r_p1x), .i_ay(r_p1y), .i_bx(r_p2x), .i_by(r_p2y),
      .i_px(r_cx),  .i_py(r_cy),  .o_neg(w_neg12), .o_pos(w_pos12)
   );

   tri_edge_sign #(.COORD_W(COORD_W)) u_e23 (
      .i_ax(r_p2x), .i_ay(r_p2y), .i_bx(r_p3x), .i_by(r_p3y),
      .i_px(r_cx),  .i_py(r_cy),  .o_neg(w_neg23), .o_pos(w_pos23)
   );

   tri_edge_sign #(.COORD_W(COORD_W)) u_e31 (
      .i_ax(r_p3x), .i_ay(r_p3y), .i_bx(r_p1x), .i_by(r_p1y),
      .i_px(r_cx),  .i_py(r_cy),  .o_neg(w_neg31), .o_pos(w_pos31)
   );

   // Covered unless the edges disagree strictly; on-edge (d=0) never vetoes, so winding does not matter.
   assign w_inside = !((w_neg12 || w_neg23 || w_neg31) && (w_pos12 || w_pos23 || w_pos31));

`ifdef EMIT_ALL_EN
   assign w_emit = 1'b1;
   assign w_flag = w_inside;
`else
   assign w_emit = w_inside;
   assign w_flag = 1'b1;
`endif

   assign w_adv      = !r_pix_valid || bus.pix_ready;
   assign w_last_col = (r_cx == r_xmax);
   assign w_last_row = (r_cy == r_ymax);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_tri_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_p1x        <= '0;
         r_p1y        <= '0;
         r_p2x        <= '0;
         r_p2y        <= '0;
         r_p3x        <= '0;
         r_p3y        <= '0;
         r_xmin       <= '0;
         r_xmax       <= '0;
         r_ymax       <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_pix_valid  <= 1'b0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_pix_inside <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_tri_ready) begin
                  r_tri_ready <= 1'b1;
               end else if (bus.tri_valid) begin
                  r_p1x       <= bus.p1x;
                  r_p1y       <= bus.p1y;
                  r_p2x       <= bus.p2x;
                  r_p2y       <= bus.p2y;
                  r_p3x       <= bus.p3x;
                  r_p3y       <= bus.p3y;
                  r_tri_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= BBOX;
               end
            end
            BBOX: begin
               r_xmin  <= min3(r_p1x, r_p2x, r_p3x);
               r_xmax  <= max3(r_p1x, r_p2x, r_p3x);
               r_ymax  <= max3(r_p1y, r_p2y, r_p3y);
               r_cx    <= min3(r_p1x, r_p2x, r_p3x);
               r_cy    <= min3(r_p1y, r_p2y, r_p3y);
               r_state <= SCAN;
            end
            SCAN: begin
               if (w_adv) begin
                  if (w_emit) begin
                     r_pix_valid  <= 1'b1;
                     r_pix_x      <= r_cx;
                     r_pix_y      <= r_cy;
                     r_pix_inside <= w_flag;
                  end else begin
                     r_pix_valid  <= 1'b0;
                  end
                  // Compare before incrementing so the top coordinate never wraps.
                  if (w_last_col) begin
                     if (w_last_row) begin
                        r_state <= DRAIN;
                     end else begin
                        r_cx <= r_xmin;
                        r_cy <= r_cy + 1'b1;
                     end
                  end else begin
                     r_cx <= r_cx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_adv) begin
                  r_pix_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_tri_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.tri_ready  = r_tri_ready;
   assign bus.pix_valid  = r_pix_valid;
   assign bus.pix_x      = r_pix_x;
   assign bus.pix_y      = r_pix_y;
   assign bus.pix_inside = r_pix_inside;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule
